// File: rtl/hilo_muldiv_unit_pkg.sv
// mips_muldiv_pkg: shared op encodings, FSM states and default width for the HI/LO mul/div unit
package mips_muldiv_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   localparam int WIDTH_DEF = 32;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: controller-side request/result bundle of the HI/LO mul/div unit
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, op, a, b, mthi, mtlo, wdata,
                   input  busy, done, div_by_zero, hi, lo);
   modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                   output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring-divide step
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_o
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] rsh;
   logic [WIDTH:0] diff;
   // multiply: acc = {partial product, remaining multiplier bits}; add when the low bit is set, then shift right
   assign sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd} : '0);
   // divide: acc = {remainder, remaining dividend bits}; shift left one bit and try to subtract the divisor
   assign rsh  = acc_i[2*WIDTH-1:WIDTH-1];
   assign diff = rsh - {1'b0, opnd};
   assign acc_o = !is_div    ? {sum, acc_i[WIDTH-1:1]} :
                  diff[WIDTH] ? {rsh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0} :
                                {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle mult/div engine owning the architectural HI/LO registers
module hilo_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   hilo_muldiv_unit_if.slave bus
);
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 dz_q, dz_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 div_by_zero_q, div_by_zero_d;
   logic                 sa, sb, dz;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   step_acc, prod;
   logic [WIDTH-1:0]     acc_hi, acc_lo;
   assign sa    = (bus.op == OP_MULT || bus.op == OP_DIV) && bus.a[WIDTH-1];
   assign sb    = (bus.op == OP_MULT || bus.op == OP_DIV) && bus.b[WIDTH-1];
   assign mag_a = sa ? -bus.a : bus.a;
   assign mag_b = sb ? -bus.b : bus.b;
   assign dz    = bus.op[1] && bus.b == '0;
   assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
   assign acc_lo = acc_q[WIDTH-1:0];
   assign prod   = neg_lo_q ? -acc_q : acc_q;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (is_div_q),
      .acc_i  (acc_q),
      .opnd   (opnd_q),
      .acc_o  (step_acc)
   );
   // next-state: accept requests in IDLE, iterate in CALC, sign-fix and publish HI/LO in FIX
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_div_d      = is_div_q;
      dz_d          = dz_q;
      neg_lo_d      = neg_lo_q;
      neg_hi_d      = neg_hi_q;
      opnd_d        = opnd_q;
      acc_d         = acc_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      done_d        = 1'b0;
      div_by_zero_d = div_by_zero_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d       = dz ? FIX : CALC;
               cnt_d         = '0;
               is_div_d      = bus.op[1];
               dz_d          = dz;
               neg_lo_d      = !dz && (sa ^ sb);
               neg_hi_d      = !dz && (bus.op[1] ? sa : sa ^ sb);
               opnd_d        = bus.op[1] ? mag_b : mag_a;
               acc_d         = dz ? {bus.a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
               div_by_zero_d = 1'b0;
            end else begin
               hi_d = bus.mthi ? bus.wdata : hi_q;
               lo_d = bus.mtlo ? bus.wdata : lo_q;
            end
         end
         CALC: begin
            acc_d   = step_acc;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CNT_W'(WIDTH - 1) ? FIX : CALC;
         end
         FIX: begin
            hi_d          = is_div_q ? (neg_hi_q ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
            lo_d          = is_div_q ? (neg_lo_q ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
            done_d        = 1'b1;
            div_by_zero_d = dz_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state register with synchronous reset that aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         is_div_q      <= 1'b0;
         dz_q          <= 1'b0;
         neg_lo_q      <= 1'b0;
         neg_hi_q      <= 1'b0;
         opnd_q        <= '0;
         acc_q         <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         done_q        <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_div_q      <= is_div_d;
         dz_q          <= dz_d;
         neg_lo_q      <= neg_lo_d;
         neg_hi_q      <= neg_hi_d;
         opnd_q        <= opnd_d;
         acc_q         <= acc_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         done_q        <= done_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end
   assign bus.busy        = state_q != IDLE;
   assign bus.done        = done_q;
   assign bus.div_by_zero = div_by_zero_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: randomized and directed checks of the HI/LO mul/div unit against an arithmetic model
module tb_hilo_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   hilo_muldiv_unit_if #(.WIDTH(32)) bus ();
   hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      if (op == 2'b00) res = sa * sb;
      else if (op == 2'b01) res = {32'b0, a} * {32'b0, b};
      else if (b == 0) res = {a, 32'hFFFF_FFFF};
      else if (op == 2'b10) begin
         q = sa / sb;
         r = sa % sb;
         res = {r[31:0], q[31:0]};
      end else res = {a % b, a / b};
      return res;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      bus.mtlo  = 1'b0;
   endtask
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic with_mt);
      int n;
      int bad_busy;
      logic [63:0] exp;
      logic dzx;
      exp = ref_res(op, a, b);
      dzx = op[1] && b == 0;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.mthi  = with_mt;
      bus.mtlo  = with_mt;
      bus.wdata = 32'h1234_5678;
      tick();
      idle_inputs();
      chk("stale_hi", {32'b0, bus.hi}, {32'b0, m_hi});
      chk("dbz_clear", {63'b0, bus.div_by_zero}, 64'd0);
      n = 0;
      bad_busy = 0;
      while (!bus.done && n < 100) begin
         if (!bus.busy) bad_busy++;
         bus.start = 1'b1;
         bus.mthi  = 1'b1;
         bus.wdata = 32'hBAD0_BAD0;
         tick();
         idle_inputs();
         n++;
      end
      chk("latency", 64'(n), dzx ? 64'd1 : 64'd33);
      chk("busy_during", 64'(bad_busy), 64'd0);
      chk("busy_done", {63'b0, bus.busy}, 64'd0);
      chk("result", {bus.hi, bus.lo}, exp);
      chk("dbz", {63'b0, bus.div_by_zero}, {63'b0, dzx});
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      tick();
      chk("done_pulse", {63'b0, bus.done}, 64'd0);
   endtask
   initial begin
      logic [1:0] op;
      logic [31:0] a, b;
      idle_inputs();
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      bus.wdata = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_state", {59'b0, bus.busy, bus.done, bus.div_by_zero, 2'b0}, 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
      do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
      do_op(2'b11, 32'd7, 32'd0, 1'b0);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b1);
      do_op(2'b00, 32'd6, 32'd7, 1'b1);
      bus.mthi = 1'b1;
      bus.wdata = 32'h0000_DEAD;
      tick();
      idle_inputs();
      m_hi = 32'h0000_DEAD;
      chk("mthi_idle", {bus.hi, bus.lo}, {m_hi, m_lo});
      chk("mthi_no_done", {63'b0, bus.done}, 64'd0);
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      bus.wdata = 32'hCAFE_F00D;
      tick();
      idle_inputs();
      m_hi = 32'hCAFE_F00D;
      m_lo = 32'hCAFE_F00D;
      chk("mthi_mtlo", {bus.hi, bus.lo}, {m_hi, m_lo});
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'd11;
      bus.b = 32'd13;
      tick();
      idle_inputs();
      for (int i = 0; i < 14; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) chk("rst_no_done", {63'b0, bus.done}, 64'd0);
         tick();
      end
      chk("rst_quiet", {63'b0, bus.done}, 64'd0);
      do_op(2'b00, 32'd3, 32'd3, 1'b0);
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op(op, a, b, 1'($urandom_range(0, 1)));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
